// File: rtl/readout_seq_mc_if.sv
// Control inputs and column/ADC outputs of the row readout sequencer.
// The controller side uses master, the sequencer uses slave.
interface readout_seq_mc_if #(
    parameter int NUM_ADC = 2,
    parameter int ROW_W   = 10,
    parameter int LAT_W   = 5,
    parameter int BANK_W  = 1
);
    logic                     trigger;
    logic                     abort;
    logic                     re_busy;
    logic                     ro_done;
    logic [ROW_W-1:0]         NUM_ROW;
    logic [ROW_W-1:0]         ROW_START;
    logic [31:0]              T_ROW;
    logic [31:0]              T_PRECH;
    logic [31:0]              T_MUX;
    logic [31:0]              T_DLY;
    logic [31:0]              T_FAST;
    logic [NUM_ADC*LAT_W-1:0] Tlat;
    logic [ROW_W-1:0]         ROWADD;
    logic [BANK_W-1:0]        BANK_SEL;
    logic                     COL_L_EN;
    logic                     COL_PRECH;
    logic                     MUX_START;
    logic                     CP_MUX_IN;
    logic                     adc_rd;
    logic [NUM_ADC-1:0]       adc_dat_valid;

    modport master (
        output trigger, abort, NUM_ROW, ROW_START, T_ROW, T_PRECH, T_MUX, T_DLY, T_FAST, Tlat,
        input  re_busy, ro_done, ROWADD, BANK_SEL, COL_L_EN, COL_PRECH, MUX_START, CP_MUX_IN,
               adc_rd, adc_dat_valid
    );

    modport slave (
        input  trigger, abort, NUM_ROW, ROW_START, T_ROW, T_PRECH, T_MUX, T_DLY, T_FAST, Tlat,
        output re_busy, ro_done, ROWADD, BANK_SEL, COL_L_EN, COL_PRECH, MUX_START, CP_MUX_IN,
               adc_rd, adc_dat_valid
    );
endinterface

// File: rtl/readout_seq_mc.sv
// Row readout sequencer: scans rows split into column banks, drives the column
// strobes and adc_rd, and produces a per-channel latency-delayed data-valid.
module readout_seq_mc #(
    parameter int NUM_BANK = 2,
    parameter int NUM_ADC  = 2,
    parameter int ROW_W    = 10,
    parameter int LAT_W    = 5,
    parameter int TRIG_DLY = 15,
    parameter int BANK_W   = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
    input  logic             CLK,
    input  logic             rst,
    readout_seq_mc_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam int DEPTH = 1 << LAT_W;
    localparam int ARM_W = (TRIG_DLY > 1) ? $clog2(TRIG_DLY) : 1;

    logic [1:0]        state_q, state_d;
    logic [2:0]        trig_sync_q;
    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [31:0]       slot_q, slot_d;
    logic [31:0]       dly_q, dly_d;
    logic [31:0]       fast_q, fast_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ROW_W-1:0]  rowadd_q, rowadd_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
    logic              ro_done_q, ro_done_d;
    logic              latch_en;
    logic [ROW_W-1:0]  num_row_q;
    logic [31:0]       t_row_q, t_prech_q, t_mux_q, t_dly_q, t_fast_q;

    logic              trig_edge;
    logic              run;
    logic              slot_end;
    logic              dly_done;
    logic [31:0]       t_row_eff;
    logic [31:0]       adc_thr;
    logic              adc_rd_s;
    logic [NUM_ADC-1:0] valid_s;

    // [0],[1] form the synchroniser; [2] holds the previous synchronised level
    assign trig_edge = trig_sync_q[1] & ~trig_sync_q[2];
    assign run       = (state_q == ST_RUN);
    assign t_row_eff = (t_row_q == 32'd0) ? 32'd1 : t_row_q;
    assign slot_end  = (slot_q == t_row_eff - 32'd1);
    assign dly_done  = (dly_q >= t_dly_q);
    assign adc_thr   = (t_fast_q >= t_dly_q) ? 32'd0 : (t_dly_q - t_fast_q);
    assign adc_rd_s  = run && (dly_q >= adc_thr);

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        slot_d    = slot_q;
        dly_d     = dly_q;
        fast_d    = fast_q;
        bank_d    = bank_q;
        rowadd_d  = rowadd_q;
        row_cnt_d = row_cnt_q;
        ro_done_d = 1'b0;
        latch_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_edge) begin
                    state_d   = ST_ARM;
                    arm_cnt_d = '0;
                end
            end
            ST_ARM: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (arm_cnt_q == ARM_W'(TRIG_DLY - 1)) begin
                    latch_en = 1'b1;
                    if (bus.NUM_ROW == '0) begin
                        state_d   = ST_IDLE;
                        ro_done_d = 1'b1;
                    end else begin
                        state_d   = ST_RUN;
                        rowadd_d  = bus.ROW_START;
                        row_cnt_d = '0;
                        bank_d    = '0;
                    end
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (slot_end) begin
                    slot_d = '0;
                    dly_d  = '0;
                    fast_d = '0;
                    if (bank_q != BANK_W'(NUM_BANK - 1)) begin
                        bank_d = bank_q + BANK_W'(1);
                    end else begin
                        bank_d    = '0;
                        rowadd_d  = rowadd_q + ROW_W'(1);
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                        if (row_cnt_q == num_row_q - ROW_W'(1)) begin
                            state_d   = ST_IDLE;
                            ro_done_d = 1'b1;
                        end
                    end
                end else begin
                    slot_d = slot_q + 32'd1;
                    if (!dly_done) begin
                        dly_d = dly_q + 32'd1;
                    end else if (t_fast_q == 32'd0 || fast_q == t_fast_q - 32'd1) begin
                        fast_d = '0;
                    end else begin
                        fast_d = fast_q + 32'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Row/bank read zero and slot timers restart whenever the sequencer is not scanning
        if (state_d == ST_IDLE) begin
            rowadd_d = '0;
            bank_d   = '0;
        end
        if (state_d != ST_RUN) begin
            slot_d = '0;
            dly_d  = '0;
            fast_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            trig_sync_q <= '0;
            arm_cnt_q   <= '0;
            slot_q      <= '0;
            dly_q       <= '0;
            fast_q      <= '0;
            bank_q      <= '0;
            rowadd_q    <= '0;
            row_cnt_q   <= '0;
            ro_done_q   <= 1'b0;
            num_row_q   <= '0;
            t_row_q     <= '0;
            t_prech_q   <= '0;
            t_mux_q     <= '0;
            t_dly_q     <= '0;
            t_fast_q    <= '0;
        end else begin
            state_q     <= state_d;
            trig_sync_q <= {trig_sync_q[1:0], bus.trigger};
            arm_cnt_q   <= arm_cnt_d;
            slot_q      <= slot_d;
            dly_q       <= dly_d;
            fast_q      <= fast_d;
            bank_q      <= bank_d;
            rowadd_q    <= rowadd_d;
            row_cnt_q   <= row_cnt_d;
            ro_done_q   <= ro_done_d;
            if (latch_en) begin
                num_row_q <= bus.NUM_ROW;
                t_row_q   <= bus.T_ROW;
                t_prech_q <= bus.T_PRECH;
                t_mux_q   <= bus.T_MUX;
                t_dly_q   <= bus.T_DLY;
                t_fast_q  <= bus.T_FAST;
            end
        end
    end

    // Delay lines shift in every state so a frame's tail drains after it ends
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ADC; gi++) begin : g_lat
            logic [DEPTH-1:0] line_q;
            logic [LAT_W-1:0] tlat;
            assign tlat = bus.Tlat[gi*LAT_W +: LAT_W];
            always_ff @(posedge CLK) begin
                if (rst) begin
                    line_q <= '0;
                end else begin
                    line_q <= {line_q[DEPTH-2:0], adc_rd_s};
                end
            end
            assign valid_s[gi] = (tlat == '0) ? adc_rd_s : line_q[tlat - LAT_W'(1)];
        end
    endgenerate

    assign bus.re_busy       = (state_q != ST_IDLE);
    assign bus.ro_done       = ro_done_q;
    assign bus.ROWADD        = rowadd_q;
    assign bus.BANK_SEL      = bank_q;
    assign bus.COL_L_EN      = run && (bank_q == '0);
    assign bus.COL_PRECH     = run && (slot_q < t_prech_q);
    assign bus.MUX_START     = run && (slot_q < t_mux_q);
    assign bus.CP_MUX_IN     = run && dly_done && (fast_q < (t_fast_q >> 1));
    assign bus.adc_rd        = adc_rd_s;
    assign bus.adc_dat_valid = valid_s;
endmodule

// File: tb/tb_readout_seq_mc.sv
// Scoreboard bench: stimulus queues expected output transitions (signal, cycle,
// value); a negedge monitor pops and compares each transition it observes.
module tb_readout_seq_mc;
    localparam int NSIG = 11;

    typedef struct {
        int          sig;
        int          cyc;
        logic [31:0] val;
    } ev_t;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    ev_t  exp_q[$];
    logic [NSIG-1:0] mask = '0;
    logic [31:0] prev_v [NSIG];
    logic [31:0] mon_cur;

    readout_seq_mc_if #(.NUM_ADC(2), .ROW_W(10), .LAT_W(5), .BANK_W(1)) bus ();

    readout_seq_mc #(
        .NUM_BANK(2), .NUM_ADC(2), .ROW_W(10), .LAT_W(5), .TRIG_DLY(15), .BANK_W(1)
    ) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] sig_val(int s);
        case (s)
            0:       return {31'd0, bus.re_busy};
            1:       return {31'd0, bus.ro_done};
            2:       return {22'd0, bus.ROWADD};
            3:       return {31'd0, bus.BANK_SEL};
            4:       return {31'd0, bus.COL_L_EN};
            5:       return {31'd0, bus.COL_PRECH};
            6:       return {31'd0, bus.MUX_START};
            7:       return {31'd0, bus.CP_MUX_IN};
            8:       return {31'd0, bus.adc_rd};
            9:       return {31'd0, bus.adc_dat_valid[0]};
            10:      return {31'd0, bus.adc_dat_valid[1]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic string sig_name(int s);
        case (s)
            0:       return "re_busy";
            1:       return "ro_done";
            2:       return "ROWADD";
            3:       return "BANK_SEL";
            4:       return "COL_L_EN";
            5:       return "COL_PRECH";
            6:       return "MUX_START";
            7:       return "CP_MUX_IN";
            8:       return "adc_rd";
            9:       return "valid0";
            10:      return "valid1";
            default: return "?";
        endcase
    endfunction

    task automatic match_event(int s, logic [31:0] v);
        int idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].sig == s) idx = i;
        n_vec++;
        if (idx < 0) begin
            n_bad++;
            $display("FAIL %s: unexpected change to %0d at cycle %0d", sig_name(s), v, cyc);
        end else begin
            if (exp_q[idx].cyc != cyc || exp_q[idx].val != v) begin
                n_bad++;
                $display("FAIL %s: got %0d at cycle %0d, expected %0d at cycle %0d",
                         sig_name(s), v, cyc, exp_q[idx].val, exp_q[idx].cyc);
            end else begin
                $display("ok   %s -> %0d at cycle %0d", sig_name(s), v, cyc);
            end
            exp_q.delete(idx);
        end
    endtask

    always @(negedge CLK) begin
        for (int s = 0; s < NSIG; s++) begin
            mon_cur = sig_val(s);
            if (mask[s] && !rst && mon_cur !== prev_v[s]) match_event(s, mon_cur);
            prev_v[s] = mon_cur;
        end
    end

    task automatic ex(int s, int c, int v);
        ev_t e;
        e.sig = s;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic tick_to(int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic fire(output int t0);
        @(posedge CLK);
        #1;
        bus.trigger = 1'b1;
        t0 = cyc;
    endtask

    task automatic set_cfg(int nr, int rs, int trow, int tp, int tm, int td, int tf);
        bus.NUM_ROW   = 10'(nr);
        bus.ROW_START = 10'(rs);
        bus.T_ROW     = trow;
        bus.T_PRECH   = tp;
        bus.T_MUX     = tm;
        bus.T_DLY     = td;
        bus.T_FAST    = tf;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        while (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: missing change to %0d, expected at cycle %0d",
                     sig_name(exp_q[0].sig), exp_q[0].val, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        repeat (40) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, r;
        bus.trigger = 1'b0;
        bus.abort   = 1'b0;
        bus.Tlat    = {5'd21, 5'd0};
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int s = 0; s < NSIG; s++) begin
            n_vec++;
            if (sig_val(s) !== 32'd0) begin
                n_bad++;
                $display("FAIL reset %s: got %0d, expected 0", sig_name(s), sig_val(s));
            end else begin
                $display("ok   reset %s = 0", sig_name(s));
            end
        end
        @(posedge CLK);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Frame scan, bank alternation, latched config, ignored retrigger
        set_cfg(3, 5, 20, 1, 0, 0, 0);
        mask = 11'b000_0011_1111;
        fire(t0);
        r = t0 + 18;
        ex(0, t0 + 3, 1); ex(0, r + 120, 0);
        ex(1, r + 120, 1); ex(1, r + 121, 0);
        for (int k = 0; k < 3; k++) ex(2, r + 40 * k, 5 + k);
        ex(2, r + 120, 0);
        for (int k = 1; k <= 6; k++) ex(3, r + 20 * k, k % 2);
        for (int k = 0; k < 6; k++) ex(4, r + 20 * k, (k % 2 == 0) ? 1 : 0);
        for (int k = 0; k < 6; k++) begin
            ex(5, r + 20 * k, 1);
            ex(5, r + 20 * k + 1, 0);
        end
        tick_to(t0 + 5);  bus.trigger = 1'b0;
        tick_to(r + 10);  set_cfg(1, 0, 7, 3, 3, 0, 0);
        tick_to(r + 30);  bus.trigger = 1'b1;
        tick_to(r + 50);  bus.trigger = 1'b0;
        drain(400);

        // Strobe timing inside a slot and delayed data-valids
        set_cfg(1, 0, 12, 4, 2, 6, 4);
        mask = 11'b111_1110_0011;
        fire(t0);
        r = t0 + 18;
        ex(0, t0 + 3, 1); ex(0, r + 24, 0);
        ex(1, r + 24, 1); ex(1, r + 25, 0);
        for (int k = 0; k < 2; k++) begin
            ex(5, r + 12 * k, 1);      ex(5, r + 12 * k + 4, 0);
            ex(6, r + 12 * k, 1);      ex(6, r + 12 * k + 2, 0);
            ex(7, r + 12 * k + 6, 1);  ex(7, r + 12 * k + 8, 0);
            ex(7, r + 12 * k + 10, 1); ex(7, r + 12 * k + 12, 0);
            ex(8, r + 12 * k + 2, 1);  ex(8, r + 12 * k + 12, 0);
            ex(9, r + 12 * k + 2, 1);  ex(9, r + 12 * k + 12, 0);
            ex(10, r + 12 * k + 23, 1); ex(10, r + 12 * k + 33, 0);
        end
        tick_to(t0 + 5);  bus.trigger = 1'b0;
        drain(400);

        // Row address wrap
        set_cfg(4, 1022, 3, 0, 0, 0, 0);
        mask = 11'b000_0000_0111;
        fire(t0);
        r = t0 + 18;
        ex(0, t0 + 3, 1); ex(0, r + 24, 0);
        ex(1, r + 24, 1); ex(1, r + 25, 0);
        ex(2, r, 1022); ex(2, r + 6, 1023); ex(2, r + 12, 0); ex(2, r + 18, 1); ex(2, r + 24, 0);
        tick_to(t0 + 5);  bus.trigger = 1'b0;
        drain(400);

        // Abort mid-frame, abort in IDLE, abort on the final slot end
        set_cfg(3, 2, 5, 1, 0, 0, 0);
        mask = 11'b000_0010_0111;
        fire(t0);
        r = t0 + 18;
        ex(0, t0 + 3, 1); ex(0, r + 8, 0);
        ex(2, r, 2); ex(2, r + 8, 0);
        ex(5, r, 1); ex(5, r + 1, 0); ex(5, r + 5, 1); ex(5, r + 6, 0);
        tick_to(t0 + 5);  bus.trigger = 1'b0;
        tick_to(r + 7);   bus.abort = 1'b1;
        tick_to(r + 8);   bus.abort = 1'b0;
        drain(400);
        bus.abort = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        bus.abort = 1'b0;
        set_cfg(1, 2, 5, 1, 0, 0, 0);
        fire(t0);
        r = t0 + 18;
        ex(0, t0 + 3, 1); ex(0, r + 10, 0);
        ex(2, r, 2); ex(2, r + 10, 0);
        ex(5, r, 1); ex(5, r + 1, 0); ex(5, r + 5, 1); ex(5, r + 6, 0);
        tick_to(t0 + 5);  bus.trigger = 1'b0;
        tick_to(r + 9);   bus.abort = 1'b1;
        tick_to(r + 10);  bus.abort = 1'b0;
        drain(400);

        // Empty frame: ro_done at ARM exit, no strobes
        set_cfg(0, 3, 8, 4, 2, 3, 0);
        mask = 11'b111_1110_0011;
        fire(t0);
        ex(0, t0 + 3, 1); ex(0, t0 + 18, 0);
        ex(1, t0 + 18, 1); ex(1, t0 + 19, 0);
        tick_to(t0 + 5);  bus.trigger = 1'b0;
        drain(400);

        // T_FAST=0: no CP_MUX_IN, adc_rd from timer T_DLY
        set_cfg(1, 0, 8, 0, 0, 3, 0);
        fire(t0);
        r = t0 + 18;
        ex(0, t0 + 3, 1); ex(0, r + 16, 0);
        ex(1, r + 16, 1); ex(1, r + 17, 0);
        for (int k = 0; k < 2; k++) begin
            ex(8, r + 8 * k + 3, 1);   ex(8, r + 8 * k + 8, 0);
            ex(9, r + 8 * k + 3, 1);   ex(9, r + 8 * k + 8, 0);
            ex(10, r + 8 * k + 24, 1); ex(10, r + 8 * k + 29, 0);
        end
        tick_to(t0 + 5);  bus.trigger = 1'b0;
        drain(400);

        // Reset mid-frame clears the frame and the delay lines
        set_cfg(2, 9, 10, 0, 0, 0, 0);
        mask = 11'b111_0000_0101;
        fire(t0);
        r = t0 + 18;
        ex(0, t0 + 3, 1); ex(0, r + 6, 0);
        ex(2, r, 9); ex(2, r + 6, 0);
        ex(8, r, 1); ex(8, r + 6, 0);
        ex(9, r, 1); ex(9, r + 6, 0);
        tick_to(t0 + 5);  bus.trigger = 1'b0;
        tick_to(r + 5);   rst = 1'b1;
        tick_to(r + 6);   rst = 1'b0;
        drain(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/readout_seq_mc.md
Name: readout_seq_mc

Overview:
- Parametrised row readout sequencer for the column-parallel sensor ADC path.
- Scans NUM_ROW rows from a programmable start row. Each row is split into NUM_BANK column banks, replacing the fixed left/right pair.
- Drives the column control strobes and adc_rd.
- Generates one latency-aligned data-valid per ADC channel, all in the single CLK domain.
- Sits between the frame/exposure controller (trigger/re_busy handshake) and the ADC deserialiser FIFOs.

Parameters:
NUM_BANK, 2, column banks per row (>=1)
NUM_ADC, 2, ADC channels needing a delayed data-valid
ROW_W, 10, width of ROWADD / row counters
LAT_W, 5, latency select width; each delay line is 2^LAT_W deep
TRIG_DLY, 15, cycles from trigger edge to first bank
BANK_W, 1, width of BANK_SEL, = max(1, clog2(NUM_BANK))

Ports:
CLK  in  1  system clock
rst  in  1  synchronous active-high reset
trigger  in  1  frame readout request (level; rising edge used)
abort  in  1  terminate current frame
re_busy  out  1  high from accepted trigger until frame end
ro_done  out  1  one-cycle pulse at normal frame completion
NUM_ROW  in  ROW_W  rows per frame
ROW_START  in  ROW_W  first row address
T_ROW  in  32  cycles per bank slot
T_PRECH  in  32  COL_PRECH width from slot start
T_MUX  in  32  MUX_START width from slot start
T_DLY  in  32  delay before CP_MUX_IN toggling
T_FAST  in  32  CP_MUX_IN period
Tlat  in  NUM_ADC*LAT_W  per-channel valid latency, channel i at [i*LAT_W +: LAT_W]
ROWADD  out  ROW_W  current row address
BANK_SEL  out  BANK_W  current bank
COL_L_EN  out  1  high while BANK_SEL==0
COL_PRECH, MUX_START, CP_MUX_IN, adc_rd  out  1 each  column/ADC strobes
adc_dat_valid  out  NUM_ADC  delayed adc_rd per channel

Behaviour:
- Single clock CLK. Reset is synchronous and active-high (rst).
- Reset values:
  - state IDLE; all counters 0.
  - ROWADD=0, BANK_SEL=0; all strobes 0; re_busy=0, ro_done=0.
  - Delay lines cleared; adc_dat_valid=0.
- Trigger handling:
  - trigger passes through a 2-FF synchroniser, then a rising-edge detect.
  - Edges outside IDLE are ignored (no queuing).
- States and transitions:
  - IDLE: ROWADD=0, BANK_SEL=0. A trigger edge moves to ARM and sets re_busy the next cycle.
  - ARM: counts TRIG_DLY cycles. On the last cycle it latches NUM_ROW, ROW_START, T_ROW, T_PRECH, T_MUX, T_DLY, T_FAST into shadow registers; mid-frame input changes have no effect.
  - ARM exit with latched NUM_ROW==0: go to IDLE and pulse ro_done.
  - ARM exit otherwise: go to RUN with ROWADD=ROW_START, BANK_SEL=0.
  - RUN: slot timer runs 0..T_ROW-1; T_ROW=0 is treated as 1. At slot end:
    - slot timer, delay timer and fast timer clear;
    - if BANK_SEL<NUM_BANK-1, BANK_SEL increments;
    - otherwise BANK_SEL=0, ROWADD increments (wraps mod 2^ROW_W) and the row counter increments;
    - after NUM_ROW rows: IDLE, ro_done=1 for one cycle, re_busy=0 on the same edge.
- Delay/fast timers within a slot:
  - Delay timer counts up and saturates at T_DLY.
  - Once the delay timer reaches T_DLY, the fast timer runs 0..T_FAST-1 and wraps.
  - T_FAST=0: fast timer held at 0, CP_MUX_IN=0.
- Strobes are combinational from state and timers; 0 outside RUN.
  - COL_PRECH = timer<T_PRECH.
  - MUX_START = timer<T_MUX.
  - CP_MUX_IN = delay timer reached T_DLY AND fast timer < T_FAST/2 (floor).
  - adc_rd = delay timer >= T_DLY-T_FAST. The subtraction saturates at 0, so adc_rd=1 for the whole slot when T_FAST>=T_DLY.
- Delay lines:
  - Each channel has a 2^LAT_W-bit shift register fed by adc_rd every CLK.
  - adc_dat_valid[i] = line[Tlat_i-1] for Tlat_i>=1; Tlat_i=0 gives adc_rd directly.
  - Tlat is not latched; it can change live.
  - Lines keep shifting in all states, so the tail of a frame flushes after it ends.
- Abort:
  - abort=1 in ARM or RUN: next state IDLE, strobes 0, re_busy=0, no ro_done.
  - Lines keep shifting, so only already-issued valids drain.
  - abort in IDLE has no effect.
  - abort has priority over slot-end and row-end on the same cycle.
- rst mid-frame returns everything to reset values on the next edge, including the delay lines.

Test Plan:
1. NUM_BANK=2, NUM_ROW=3, ROW_START=5, T_ROW=20, trigger edge:
   - re_busy rises 3 cycles after the edge (2 sync + 1);
   - first RUN cycle is TRIG_DLY cycles later;
   - ROWADD sequence 5,5,6,6,7,7 per 20-cycle slot; COL_L_EN high on bank 0 slots only;
   - ro_done pulses once, 120 RUN cycles after the first RUN cycle.
2. T_PRECH=4, T_MUX=2, T_DLY=6, T_FAST=4 in one slot:
   - COL_PRECH high timer 0-3; MUX_START high timer 0-1;
   - adc_rd high from timer 2; CP_MUX_IN pattern 1,1,0,0 repeating from timer 6.
3. Tlat={0,21}, single adc_rd rising edge at cycle N:
   - adc_dat_valid[0] rises at N;
   - adc_dat_valid[1] rises at N+21; widths equal to the adc_rd width.
4. ROW_START=1022, NUM_ROW=4, ROW_W=10: ROWADD sequence 1022,1023,0,1, then ro_done.
5. abort asserted on the same cycle as the final slot end: state goes to IDLE, ro_done stays 0, re_busy drops. A second trigger edge while busy in another frame is ignored.
6. NUM_ROW=0 and T_FAST=0 cases:
   - NUM_ROW=0: ro_done pulses at ARM exit with no strobes.
   - T_FAST=0, T_DLY=3: CP_MUX_IN stays 0 and adc_rd is high from timer 3.
